// File: rtl/seq_pkg.sv
// Shared encodings for the Y86-64 multi-cycle sequencer.
package seq_pkg;

    // Y86 status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // icodes the sequencer reacts to directly
    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] IOPQ  = 4'h6;

    // Sequencer phases; the encoding is visible on the phase port
    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_FETCH     = 3'd1,
        PH_DECODE    = 3'd2,
        PH_EXECUTE   = 3'd3,
        PH_MEMORY    = 3'd4,
        PH_WRITEBACK = 3'd5,
        PH_HALT      = 3'd6
    } phase_e;

    // Width of a counter that must hold 0..max_val inclusive (at least 1 bit)
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// MEMORY-phase wait counter: counts cycles without ack, flags MAX_WAIT.
module seq_wait_timer
    import seq_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int         W     = cnt_width(MAX_WAIT);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = (count_q == LIMIT);

    // Clear wins over enable; the count saturates at the limit so it never wraps
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Y86-64 multi-cycle sequencer: phase FSM, architectural PC, status
// register and retired-instruction counter, with a memory wait timeout.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15,
    parameter int              CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [3:0]        icode,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              need_mem,
    input  logic              mem_ack,
    input  logic              dmem_error,
    input  logic [ADDR_W-1:0] newpc,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        stat,
    output logic [2:0]        phase,
    output logic              mem_req,
    output logic              cc_we,
    output logic              reg_we,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    phase_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Outputs decode straight from the state register, so an async reset
    // drops mem_req and the write enables without waiting for an edge.
    assign phase   = state_q;
    assign pc      = pc_q;
    assign stat    = stat_q;
    assign retired = retired_q;
    assign mem_req = (state_q == PH_MEMORY);
    assign cc_we   = (state_q == PH_EXECUTE) && (icode == IOPQ);
    assign reg_we  = (state_q == PH_WRITEBACK);
    assign halted  = (state_q == PH_HALT);

    // Next-state logic; stat is written only on the way into HALT and the
    // PC / retired count move only in WRITEBACK, so faults leave pc pointing
    // at the offending instruction.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;

        unique case (state_q)
            PH_IDLE: begin
                if (run) begin
                    state_d = PH_FETCH;
                end
            end

            PH_FETCH: begin
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = PH_HALT;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = PH_HALT;
                end else if (icode == IHALT) begin
                    stat_d  = STAT_HLT;
                    state_d = PH_HALT;
                end else begin
                    state_d = PH_DECODE;
                end
            end

            PH_DECODE: begin
                state_d = PH_EXECUTE;
            end

            PH_EXECUTE: begin
                if (need_mem) begin
                    tmr_clr = 1'b1;
                    state_d = PH_MEMORY;
                end else begin
                    state_d = PH_WRITEBACK;
                end
            end

            PH_MEMORY: begin
                // An ack on the cycle the timer reads MAX_WAIT still wins
                if (mem_ack) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = PH_HALT;
                    end else begin
                        state_d = PH_WRITEBACK;
                    end
                end else if (tmr_expired) begin
                    stat_d  = STAT_ADR;
                    state_d = PH_HALT;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            PH_WRITEBACK: begin
                pc_d      = newpc;
                retired_d = retired_q + CNT_W'(1);
                state_d   = run ? PH_FETCH : PH_IDLE;
            end

            PH_HALT: begin
                state_d = PH_HALT;
            end

            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PH_IDLE;
            pc_q      <= RESET_PC;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl.
module tb_seq_ctrl;

    localparam int          ADDR_W   = 64;
    localparam logic [63:0] RST_PC   = 64'h40;
    localparam int          MAX_WAIT = 15;
    localparam int          CNT_W    = 32;

    localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_EXEC = 3'd3,
                           P_MEM = 3'd4, P_WB = 3'd5, P_HALT = 3'd6;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [3:0]        icode;
    logic              instr_valid;
    logic              imem_error;
    logic              need_mem;
    logic              mem_ack;
    logic              dmem_error;
    logic [ADDR_W-1:0] newpc;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        stat;
    logic [2:0]        phase;
    logic              mem_req;
    logic              cc_we;
    logic              reg_we;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    int errors = 0;
    int checks = 0;

    seq_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .need_mem    (need_mem),
        .mem_ack     (mem_ack),
        .dmem_error  (dmem_error),
        .newpc       (newpc),
        .pc          (pc),
        .stat        (stat),
        .phase       (phase),
        .mem_req     (mem_req),
        .cc_we       (cc_we),
        .reg_we      (reg_we),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // From IDLE or WRITEBACK with run=1, steps one instruction until it
    // reaches WRITEBACK or HALT. ack_at = index of the MEMORY cycle carrying
    // mem_ack (0 = never).
    task automatic run_instr(input logic [3:0] ic, input logic nm, input int ack_at,
                             input logic derr, input logic [63:0] npc,
                             output int total, output int mcyc, output int mreq,
                             output int ccw, output int cc_at);
        icode = ic; need_mem = nm; newpc = npc; dmem_error = derr; mem_ack = 1'b0;
        total = 0; mcyc = 0; mreq = 0; ccw = 0; cc_at = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            mem_ack = 1'b0;
            if (phase != P_IDLE) total++;
            if (mem_req) mreq++;
            if (cc_we) begin
                ccw++;
                cc_at = total;
            end
            if (phase == P_MEM) begin
                mcyc++;
                mem_ack = (mcyc == ack_at);
            end
            if (phase == P_WB || phase == P_HALT) begin
                mem_ack = 1'b0;
                return;
            end
        end
        chk("instr_budget", 64'(phase), 64'(P_WB));
    endtask

    int total, mcyc, mreq, ccw, cc_at;

    initial begin
        rst = 1'b1; run = 1'b0; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
        need_mem = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0; newpc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_phase", 64'(phase), 64'(P_IDLE));
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_outs", {60'd0, mem_req, cc_we, reg_we, halted}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU op: cc_we in cycle 3, reg_we in cycle 4
        run = 1'b1;
        run_instr(4'h6, 1'b0, 0, 1'b0, 64'h0A, total, mcyc, mreq, ccw, cc_at);
        chk("alu_cycles", 64'(total), 64'd4);
        chk("alu_ccw_cnt", 64'(ccw), 64'd1);
        chk("alu_ccw_at", 64'(cc_at), 64'd3);
        chk("alu_wb_we", {62'd0, reg_we, cc_we}, 64'd2);
        chk("alu_wb_pc_old", pc, RST_PC);
        step();
        chk("alu_pc", pc, 64'h0A);
        chk("alu_retired", 64'(retired), 64'd1);
        chk("alu_next_fetch", 64'(phase), 64'(P_FETCH));

        // Async reset mid-EXECUTE
        step();
        step();
        chk("exe_phase", 64'(phase), 64'(P_EXEC));
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc, RST_PC);
        chk("arst_stat", 64'(stat), 64'd1);
        chk("arst_phase", 64'(phase), 64'(P_IDLE));
        chk("arst_retired", 64'(retired), 64'd0);
        chk("arst_ccwe", 64'(cc_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Memory op, ack in the 4th MEMORY cycle; drop run during it
        run_instr(4'h5, 1'b1, 4, 1'b0, 64'h20, total, mcyc, mreq, ccw, cc_at);
        chk("mem_cycles", 64'(total), 64'd8);
        chk("mem_req_cnt", 64'(mreq), 64'd4);
        chk("mem_ccw", 64'(ccw), 64'd0);
        run = 1'b0;
        step();
        chk("mem_idle", 64'(phase), 64'(P_IDLE));
        chk("mem_pc", pc, 64'h20);
        chk("mem_retired", 64'(retired), 64'd1);

        // Second instruction then halt
        run = 1'b1;
        run_instr(4'h6, 1'b0, 0, 1'b0, 64'h30, total, mcyc, mreq, ccw, cc_at);
        icode = 4'h0;
        step();
        chk("pre_halt_pc", pc, 64'h30);
        step();
        chk("hlt_phase", 64'(phase), 64'(P_HALT));
        chk("hlt_stat", 64'(stat), 64'd2);
        chk("hlt_halted", 64'(halted), 64'd1);
        chk("hlt_retired", 64'(retired), 64'd2);
        chk("hlt_pc", pc, 64'h30);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            newpc = 64'h77;
            step();
        end
        chk("hlt_hold", {pc[15:0], 8'(retired), 5'd0, phase, 1'b0, stat}, {16'h30, 8'd2, 5'd0, P_HALT, 1'b0, 3'd2});
        chk("hlt_en_off", {61'd0, mem_req, cc_we, reg_we}, 64'd0);

        // Timeout: never ack -> 16 MEMORY cycles then ADR halt
        do_reset();
        run = 1'b1; icode = 4'h2;
        run_instr(4'h5, 1'b1, 0, 1'b0, 64'h99, total, mcyc, mreq, ccw, cc_at);
        chk("to_mcyc", 64'(mcyc), 64'd16);
        chk("to_stat", 64'(stat), 64'd3);
        chk("to_halted", 64'(halted), 64'd1);
        chk("to_pc", pc, RST_PC);
        chk("to_memreq", 64'(mem_req), 64'd0);

        // Ack on the cycle the counter sits at MAX_WAIT is accepted
        do_reset();
        run_instr(4'h4, 1'b1, 16, 1'b0, 64'h50, total, mcyc, mreq, ccw, cc_at);
        chk("late_ack_phase", 64'(phase), 64'(P_WB));
        chk("late_ack_mcyc", 64'(mcyc), 64'd16);
        step();
        chk("late_ack_pc", pc, 64'h50);

        // Data memory error
        do_reset();
        run_instr(4'h5, 1'b1, 2, 1'b1, 64'h60, total, mcyc, mreq, ccw, cc_at);
        chk("derr_stat", 64'(stat), 64'd3);
        chk("derr_pc", pc, RST_PC);
        chk("derr_retired", 64'(retired), 64'd0);

        // Async reset during MEMORY drops mem_req immediately
        do_reset();
        icode = 4'h5; need_mem = 1'b1;
        repeat (4) step();
        chk("arst_mem_req_pre", 64'(mem_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch error priority: imem_error beats invalid icode
        imem_error = 1'b1; instr_valid = 1'b0;
        run_instr(4'h6, 1'b0, 0, 1'b0, 64'h0, total, mcyc, mreq, ccw, cc_at);
        chk("prio_stat", 64'(stat), 64'd3);
        chk("prio_cycles", 64'(total), 64'd2);
        do_reset();
        imem_error = 1'b0;
        run_instr(4'h6, 1'b0, 0, 1'b0, 64'h0, total, mcyc, mreq, ccw, cc_at);
        chk("ins_stat", 64'(stat), 64'd4);
        chk("ins_halted", 64'(halted), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle sequencer for the Y86-64 sequential processor. It replaces the free-running single-cycle `pc <= newpc` update with a phased controller (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK) that:
- owns the architectural PC and the Y86 status register;
- handshakes with variable-latency data memory;
- stops the machine on halt or on an error.

It sits between the existing fetch/decode/execute/memory/pc_update datapath and the top-level testbench or SoC wrapper.

## Interface
Parameters:
- ADDR_W, 64, width of pc/newpc
- RESET_PC, 0, PC value loaded on reset
- MAX_WAIT, 15, maximum extra MEMORY cycles tolerated without mem_ack
- CNT_W, 32, width of retired-instruction counter

Ports:
- Clocking: one clock `clk`. Reset `rst` is asynchronous and active-high.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- run  in  1  level; permits starting a new instruction
- icode  in  4  decoded icode from fetch
- instr_valid  in  1  fetch: legal icode
- imem_error  in  1  fetch: PC out of instruction memory
- need_mem  in  1  instruction reads or writes data memory (MEM_read | MEM_write)
- mem_ack  in  1  data memory completion strobe
- dmem_error  in  1  data memory address error, valid with mem_ack
- newpc  in  ADDR_W  next PC from pc_update logic
- pc  out  ADDR_W  architectural PC
- stat  out  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4
- phase  out  3  current state encoding
- mem_req  out  1  data memory request, held until acknowledged
- cc_we  out  1  condition-code write enable
- reg_we  out  1  register-file write enable
- halted  out  1  machine stopped
- retired  out  CNT_W  instructions completed

## Operation
States are IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and HALT.

Reset (async, any state):
- pc=RESET_PC, stat=AOK, phase=IDLE, retired=0.
- mem_req, cc_we, reg_we and halted are all 0.

State transitions:
- IDLE: go to FETCH when run=1, else stay.
- FETCH: end-of-cycle checks in this priority order:
  - imem_error → stat=ADR, go to HALT;
  - else !instr_valid → stat=INS, go to HALT;
  - else icode==0 (halt) → stat=HLT, go to HALT;
  - else go to DECODE.
- DECODE: always go to EXECUTE.
- EXECUTE: cc_we=1 for this cycle only, and only if icode==6 (OPq). Then go to MEMORY if need_mem, else WRITEBACK.
- MEMORY:
  - mem_req=1 combinationally for every MEMORY cycle.
  - A wait counter clears on entry and increments on each cycle without mem_ack.
  - mem_ack=1 and dmem_error=1 → stat=ADR, go to HALT.
  - mem_ack=1 and dmem_error=0 → go to WRITEBACK.
  - No ack while counter==MAX_WAIT → stat=ADR, go to HALT (timeout).
- WRITEBACK: reg_we=1 for this cycle; pc<=newpc; retired<=retired+1 (wraps modulo 2^CNT_W). Then go to FETCH if run, else IDLE.
- HALT: absorbing until rst. halted=1; all enables are 0; pc and retired are frozen.

Error and halt behaviour:
- On halt or any error, pc is NOT updated; it remains the address of the faulting or halt instruction.
- The halt instruction does not increment retired.
- stat is written only on entry to HALT and holds thereafter.

## Timing
- Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
- Memory instruction: 5+k cycles, where k is the number of cycles waited for ack, 0 ≤ k ≤ MAX_WAIT.
- Halt or error detected in FETCH: HALT is entered on the next edge; halted=1 one cycle after the FETCH cycle.
- mem_ack is sampled only in MEMORY; an ack in any other state is ignored.
- The ack cycle counts as the final MEMORY cycle. An ack arriving on the cycle where counter==MAX_WAIT is accepted, not timed out.
- run is sampled only in IDLE and WRITEBACK. Dropping run mid-instruction finishes that instruction, then parks in IDLE.
- cc_we and reg_we are single-cycle pulses and are never high simultaneously.
- Async rst during MEMORY drops mem_req immediately, without waiting for a clock edge.

## Structure
- Package seq_pkg holds:
  - stat codes (STAT_AOK=1, STAT_HLT=2, STAT_ADR=3, STAT_INS=4);
  - phase encodings (IDLE=0 … HALT=6);
  - icode constants IHALT=0 and IOPQ=6.
- Sub-module seq_wait_timer: a clog2(MAX_WAIT+1)-bit counter with clear, enable and expired outputs, used for the MEMORY timeout.
- The FSM, PC register, stat register and retired counter live in seq_ctrl.

## Test plan
- **Reset:** rst pulsed mid-EXECUTE → pc=RESET_PC, stat=1, phase=IDLE, retired=0 immediately.
- **ALU op:** run=1, icode=6, need_mem=0, newpc=0x0A → cc_we pulses in cycle 3, reg_we in cycle 4, pc=0x0A and retired=1 after 4 cycles.
- **Memory with wait:** icode=5, need_mem=1, mem_ack delayed 3 cycles → mem_req high for 4 cycles, WRITEBACK follows, 8 cycles total.
- **Timeout:** MAX_WAIT=15, mem_ack never asserted → after 16 MEMORY cycles stat=3, halted=1, pc unchanged.
- **Halt:** after two retired instructions, fetch icode=0 → stat=2, halted=1, retired=2, pc=halt address; further run toggles have no effect.
- **Error priority:** FETCH with imem_error=1 and instr_valid=0 together → stat=3 (ADR), not 4.
